seg7_to_binary: RTL and testbench
=================================

Name: seg7_to_binary

Overview:
Decoder for the active-low two-digit seven-segment encoding used by the score display. It accepts segment patterns one digit at a time, most-significant digit first, over a valid/ready stream. It decodes each pattern back to a decimal digit and accumulates the digits into a binary value. The result goes out on a valid/ready result port. It is used by the self-check harness and by the board loopback path to recover the displayed score (0..63) from the segment drive lines.

Parameters:
WIDTH, 6, width of result_data; the maximum representable value is 2^WIDTH-1.
MAX_DIGITS, 2, maximum number of digits per value; a longer sequence is an error.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
seg_valid  in  1  seg_pattern holds a digit
seg_ready  out  1  block can accept a digit this cycle
seg_pattern  in  7  active-low segments, bit0=a .. bit6=g
seg_last  in  1  qualifies seg_valid: this digit is the final digit of the value
result_valid  out  1  result_data/result_error are valid
result_ready  in  1  consumer accepts the result
result_data  out  WIDTH  decoded binary value
result_error  out  1  bad pattern, too many digits, or overflow
busy  out  1  one or more digits accepted, result not yet consumed

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE, acc=0, digit count=0, error flag=0, result_valid=0, result_data=0, result_error=0, busy=0. seg_ready=0 while reset is high.
- Handshakes:
  - A digit is accepted on a cycle with seg_valid && seg_ready.
  - A result is taken on a cycle with result_valid && result_ready.
  - Upstream may hold seg_valid with no timing constraint; the block never drops an accepted digit.
- Pattern decode (combinational, active-low):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
  - 1111111 (blank) decodes as 0 and is valid.
  - Any other pattern sets the sticky error flag and contributes 0.
- States:
  - IDLE: seg_ready=1, busy=0. On digit accept: acc=digit, count=1, error=(invalid). Next state is HOLD if seg_last, else ACCUM.
  - ACCUM: seg_ready=1, busy=1. On digit accept: acc=acc*10+digit, count=count+1, error |= invalid. If count+1 > MAX_DIGITS, error |= 1. Next state is HOLD if seg_last, else ACCUM.
  - HOLD: seg_ready=0, busy=1, result_valid=1. On result_ready: result_valid=0, acc/count/error cleared, next state IDLE.
- Accumulator arithmetic:
  - acc is WIDTH+4 bits. After the multiply-add it saturates at 2^(WIDTH+4)-1, so it never wraps.
- Result formation, on entry to HOLD (registered):
  - If acc > 2^WIDTH-1: result_data = all ones and result_error=1.
  - Otherwise: result_data = acc[WIDTH-1:0] and result_error = error flag.
  - Both fields stay stable for the whole HOLD state.
- Latency: result_valid rises the cycle after the seg_last digit is accepted. The earliest next digit is accepted the cycle after the result is taken; there is no same-cycle bypass.
- Simultaneous events:
  - In HOLD, seg_valid is ignored, because seg_ready=0.
  - reset wins over every handshake.
  - Reset mid-sequence or in HOLD discards the partial value and emits no result.
- A single digit with seg_last is a valid 1-digit value.
- Overrun: after MAX_DIGITS digits without seg_last, further digits are still accepted and still accumulate, and the error flag stays set.

Test Plan:
- Reset, then send 0100100 then 0110000(last), result_ready=1 -> result_valid one cycle after the second accept, result_data=23, result_error=0, seg_ready low for exactly that cycle.
- Send 0000010 then 0011001(last), i.e. 64 -> result_data=63, result_error=1. Send 0000010 then 0110000(last), i.e. 63 -> result_data=63, result_error=0.
- Send 1111111 then 1111000(last) -> result_data=7, result_error=0. Send single 1111001(last) -> result_data=1, result_error=0.
- Send invalid 1010101 then 1000000(last) -> result_error=1. Send 3 digits 1111001, 1111001, 1111001(last) -> result_error=1.
- Hold result_ready=0 for 5 cycles with seg_valid=1 presenting 1000000 -> result_valid, result_data and result_error stable, seg_ready=0, no digit accepted. Raise result_ready -> IDLE next cycle, then 1000000 accepted.
- Pulse reset after the first digit of 4,2 -> no result_valid. A following 0010010(last) -> result_data=5.

Source files
------------

// File: rtl/seg7_to_binary.sv
// Recovers a binary score from active-low seven-segment digit patterns,
// most-significant digit first, over valid/ready streams in and out.
module seg7_to_binary #(
   parameter int WIDTH      = 6,
   parameter int MAX_DIGITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             seg_valid,
   output logic             seg_ready,
   input  logic [6:0]       seg_pattern,
   input  logic             seg_last,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] result_data,
   output logic             result_error,
   output logic             busy
);

   localparam int AW = WIDTH + 4;
   localparam int PW = AW + 4;
   localparam int CW = $clog2(MAX_DIGITS + 1) + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   localparam logic [AW-1:0] ACC_MAX   = '1;
   localparam logic [AW-1:0] RES_MAX   = AW'((1 << WIDTH) - 1);
   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic [CW-1:0] DIGIT_LIM = CW'(MAX_DIGITS);

   logic [1:0]    state;
   logic [AW-1:0] acc;
   logic [CW-1:0] count;
   logic          err;

   logic [3:0]    digit;
   logic          invalid;
   logic          seg_accept;
   logic [PW-1:0] product;
   logic [AW-1:0] acc_next;
   logic [CW-1:0] count_next;
   logic          err_next;

   assign seg_ready  = !reset && (state != HOLD);
   assign busy       = (state != IDLE);
   assign seg_accept = seg_valid && seg_ready;

   // Blank (all segments off) is a legitimate leading zero.
   always_comb begin
      digit   = 4'd0;
      invalid = 1'b0;
      case (seg_pattern)
         7'b1000000: digit = 4'd0;
         7'b1111001: digit = 4'd1;
         7'b0100100: digit = 4'd2;
         7'b0110000: digit = 4'd3;
         7'b0011001: digit = 4'd4;
         7'b0010010: digit = 4'd5;
         7'b0000010: digit = 4'd6;
         7'b1111000: digit = 4'd7;
         7'b0000000: digit = 4'd8;
         7'b0010000: digit = 4'd9;
         7'b1111111: digit = 4'd0;
         default:    invalid = 1'b1;
      endcase
   end

   // The accumulator saturates rather than wraps, so any oversized value
   // still compares above the result range and is flagged.
   always_comb begin
      product    = PW'(acc) * PW'(10) + PW'(digit);
      acc_next   = PW'(ACC_MAX) < product ? ACC_MAX : product[AW-1:0];
      count_next = (count == CNT_MAX) ? count : count + CW'(1);
      err_next   = err || invalid || (count >= DIGIT_LIM);
      if (state == IDLE) begin
         acc_next   = AW'(digit);
         count_next = CW'(1);
         err_next   = invalid;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         acc          <= '0;
         count        <= '0;
         err          <= 1'b0;
         result_valid <= 1'b0;
         result_data  <= '0;
         result_error <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (seg_accept) begin
                  acc   <= acc_next;
                  count <= count_next;
                  err   <= err_next;
                  if (seg_last) begin
                     state        <= HOLD;
                     result_valid <= 1'b1;
                     if (acc_next > RES_MAX) begin
                        result_data  <= '1;
                        result_error <= 1'b1;
                     end else begin
                        result_data  <= acc_next[WIDTH-1:0];
                        result_error <= err_next;
                     end
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            HOLD: begin
               if (result_ready) begin
                  state        <= IDLE;
                  result_valid <= 1'b0;
                  acc          <= '0;
                  count        <= '0;
                  err          <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_to_binary.sv
// Directed self-checking bench for seg7_to_binary: decode, accumulation,
// saturation, error cases, result back-pressure and mid-sequence reset.
module tb_seg7_to_binary;

   logic       clk = 1'b0;
   logic       reset;
   logic       seg_valid;
   logic       seg_ready;
   logic [6:0] seg_pattern;
   logic       seg_last;
   logic       result_valid;
   logic       result_ready;
   logic [5:0] result_data;
   logic       result_error;
   logic       busy;

   int total  = 0;
   int passed = 0;

   seg7_to_binary #(.WIDTH(6), .MAX_DIGITS(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .seg_valid    (seg_valid),
      .seg_ready    (seg_ready),
      .seg_pattern  (seg_pattern),
      .seg_last     (seg_last),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result_data  (result_data),
      .result_error (result_error),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Presents one digit and returns #1 after the edge that accepted it.
   task automatic send_digit(input logic [6:0] pat, input logic last);
      int n;
      @(negedge clk);
      seg_valid   = 1'b1;
      seg_pattern = pat;
      seg_last    = last;
      n = 0;
      while (!seg_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 50) $display("[TB] FAIL accept_timeout pattern=%b seg_ready never rose", pat);
      else passed++;
      @(posedge clk);
      #1;
      seg_valid = 1'b0;
      seg_last  = 1'b0;
   endtask

   // Expects the result already valid, checks it, then lets it be consumed.
   task automatic expect_result(input string name, input logic [5:0] exp_data, input logic exp_err);
      total++;
      if (result_valid !== 1'b1) $display("[TB] FAIL %s_valid got=%b want=1", name, result_valid);
      else passed++;
      total++;
      if (result_data !== exp_data) $display("[TB] FAIL %s_data got=%0d want=%0d", name, result_data, exp_data);
      else passed++;
      total++;
      if (result_error !== exp_err) $display("[TB] FAIL %s_error got=%b want=%b", name, result_error, exp_err);
      else passed++;
      result_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      seg_valid    = 1'b1;
      seg_pattern  = 7'b1000000;
      seg_last     = 1'b1;
      result_ready = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (seg_ready !== 1'b0) $display("[TB] FAIL reset_seg_ready got=%b want=0", seg_ready);
      else passed++;
      total++;
      if ({result_valid, result_error, busy} !== 3'b000)
         $display("[TB] FAIL reset_flags got=%b want=000", {result_valid, result_error, busy});
      else passed++;
      total++;
      if (result_data !== 6'd0) $display("[TB] FAIL reset_data got=%0d want=0", result_data);
      else passed++;
      seg_valid = 1'b0;
      seg_last  = 1'b0;
      reset     = 1'b0;
      @(negedge clk);
      total++;
      if (seg_ready !== 1'b1 || busy !== 1'b0)
         $display("[TB] FAIL idle_after_reset got ready=%b busy=%b want ready=1 busy=0", seg_ready, busy);
      else passed++;
   endtask

   task automatic test_basic_23();
      send_digit(7'b0100100, 1'b0);
      total++;
      if (busy !== 1'b1 || result_valid !== 1'b0)
         $display("[TB] FAIL basic_mid got busy=%b valid=%b want busy=1 valid=0", busy, result_valid);
      else passed++;
      send_digit(7'b0110000, 1'b1);
      total++;
      if (seg_ready !== 1'b0) $display("[TB] FAIL basic_hold_ready got=%b want=0", seg_ready);
      else passed++;
      expect_result("basic23", 6'd23, 1'b0);
      total++;
      if (result_valid !== 1'b0 || seg_ready !== 1'b1 || busy !== 1'b0)
         $display("[TB] FAIL basic_after_take got valid=%b ready=%b busy=%b want 0,1,0",
                  result_valid, seg_ready, busy);
      else passed++;
   endtask

   task automatic test_overflow();
      send_digit(7'b0000010, 1'b0);
      send_digit(7'b0011001, 1'b1);
      expect_result("ovf64", 6'd63, 1'b1);
      send_digit(7'b0000010, 1'b0);
      send_digit(7'b0110000, 1'b1);
      expect_result("edge63", 6'd63, 1'b0);
   endtask

   task automatic test_blank_and_single();
      send_digit(7'b1111111, 1'b0);
      send_digit(7'b1111000, 1'b1);
      expect_result("blank7", 6'd7, 1'b0);
      send_digit(7'b1111001, 1'b1);
      expect_result("single1", 6'd1, 1'b0);
   endtask

   task automatic test_errors();
      send_digit(7'b1010101, 1'b0);
      send_digit(7'b1000000, 1'b1);
      expect_result("badpat", 6'd0, 1'b1);
      send_digit(7'b1111001, 1'b0);
      send_digit(7'b1111001, 1'b0);
      send_digit(7'b1111001, 1'b1);
      expect_result("toolong", 6'd63, 1'b1);
   endtask

   task automatic test_back_pressure();
      result_ready = 1'b0;
      send_digit(7'b0011001, 1'b0);
      send_digit(7'b0100100, 1'b1);
      seg_valid   = 1'b1;
      seg_pattern = 7'b1000000;
      seg_last    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (result_valid !== 1'b1 || result_data !== 6'd42 || result_error !== 1'b0 || seg_ready !== 1'b0)
            $display("[TB] FAIL stall_cycle%0d got valid=%b data=%0d err=%b ready=%b want 1,42,0,0",
                     i, result_valid, result_data, result_error, seg_ready);
         else passed++;
      end
      result_ready = 1'b1;
      @(negedge clk);
      total++;
      if (result_valid !== 1'b0 || seg_ready !== 1'b1)
         $display("[TB] FAIL stall_release got valid=%b ready=%b want 0,1", result_valid, seg_ready);
      else passed++;
      @(negedge clk);
      seg_valid = 1'b0;
      seg_last  = 1'b0;
      total++;
      if (result_valid !== 1'b1 || result_data !== 6'd0 || result_error !== 1'b0)
         $display("[TB] FAIL stall_next_digit got valid=%b data=%0d err=%b want 1,0,0",
                  result_valid, result_data, result_error);
      else passed++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int seen;
      send_digit(7'b0011001, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      seen  = 0;
      repeat (4) begin
         @(negedge clk);
         if (result_valid) seen++;
      end
      total++;
      if (seen != 0 || busy !== 1'b0)
         $display("[TB] FAIL reset_mid_discard got valid_cycles=%0d busy=%b want 0,0", seen, busy);
      else passed++;
      send_digit(7'b0010010, 1'b1);
      expect_result("after_reset5", 6'd5, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic_23();
      test_overflow();
      test_blank_and_single();
      test_errors();
      test_back_pressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
